stage_fetch: RTL and testbench
==============================

Name: stage_fetch

Overview:
Instruction-fetch stage; producer side of the fetch/decode interface (instrF, pcF, pcPlus4F, bPredictedTakenF) that the decode stage registers.
- Owns the PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives the instruction-memory address and forwards returned instruction data.
- Takes redirects and predictor training from the execute stage.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX = log2(BTB_ENTRIES).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall  input  1  hold PC (decode stalled)
redirect  input  1  execute-stage mispredict or control transfer; load redirectPc
redirectPc  input  32  corrected next PC
updEn  input  1  train BTB with a resolved branch/jump
updPc  input  32  PC of the resolved instruction
updTarget  input  32  resolved target
updTaken  input  1  resolved direction
imemAddr  output  32  instruction-memory word address (equals pcF)
imemData  input  32  instruction word; combinational read of imemAddr
instrF  output  32  fetched instruction (equals imemData)
pcF  output  32  current PC
pcPlus4F  output  32  pcF + 4, modulo 2^32
bPredictedTakenF  output  1  BTB predicts taken for pcF

Behaviour:
- PC register: the only architectural state besides the BTB. Outputs are combinational from the PC and the BTB read.
- Reset values: pcF = imemAddr = RESET_PC; pcPlus4F = RESET_PC + 4; bPredictedTakenF = 0 because all valid bits are cleared; instrF follows imemData.
- Next-PC priority, evaluated each posedge:
  1. rst: load RESET_PC.
  2. redirect: load {redirectPc[31:2], 2'b00}.
  3. stall: hold PC.
  4. bPredictedTakenF: load the predicted target.
  5. Otherwise: load pcF + 4.
- redirect overrides stall in the same cycle.
- Wrap-around: pc + 4 at 32'hFFFF_FFFC yields 0. No trap is raised.
- BTB entry contents: valid(1), tag(32-IDX-2), target(30, word-aligned), ctr(2).
- BTB index and tag: index = pc[IDX+1:2]; tag = pc[31:IDX+2].
- Lookup: hit = valid & tag match. bPredictedTakenF = hit & ctr[1]. Predicted target = {target, 2'b00}.
- Update on updEn, using updPc's index and tag:
  - Hit, updTaken=1: ctr saturating increment (max 3); target := updTarget[31:2].
  - Hit, updTaken=0: ctr saturating decrement (min 0); target unchanged.
  - Miss, updTaken=1: allocate or overwrite the entry; valid=1; ctr=2'b10.
  - Miss, updTaken=0: no change.
- Update and lookup to the same index in the same cycle: the lookup sees the pre-update contents (read-before-write). The update takes effect on the next cycle.
- Training is independent of stall and redirect: BTB updates still occur during stall.
- rst asserted mid-operation: PC := RESET_PC and all valid bits := 0 on that edge. targets and ctrs need no reset. Any updEn in the rst cycle is discarded.
- Latency: a redirect at edge N sets pcF = redirectPc in cycle N+1. A trained entry predicts starting the cycle after the updEn edge.

Optional Feature:
- Macro: STAGE_FETCH_BPRED_EN.
- Defined: the BTB is instantiated and behaves as described above.
- Undefined: no BTB storage is built; bPredictedTakenF is tied 0; updEn, updPc, updTarget and updTaken are ignored. Next PC is redirect, else hold on stall, else pc + 4.

Test Plan:
- Reset with RESET_PC=32'h100 -> pcF=32'h100, pcPlus4F=32'h104, bPredictedTakenF=0. Four free-running cycles -> pcF = 104, 108, 10C, 110.
- stall held 3 cycles at pcF=32'h20 -> pcF stays 32'h20. Same stall plus redirect=1 with redirectPc=32'h203 -> next pcF=32'h200.
- updEn with updPc=32'h40, updTarget=32'h80, updTaken=1 -> on reaching pcF=32'h40, bPredictedTakenF=1 and next pcF=32'h80. Two not-taken updates to 32'h40 -> bPredictedTakenF=0 at 32'h40 (ctr 2->1->0).
- Saturation: five taken updates then one not-taken on 32'h40 -> still predicts taken (ctr 3->2). A miss with updTaken=0 at 32'h44 -> no allocation; 32'h44 never predicts taken.
- Alias (BTB_ENTRIES=16): train 32'h40 taken, then train 32'h80 taken (same index, different tag) -> 32'h40 no longer predicts taken; 32'h80 predicts taken. Same-cycle update and lookup of 32'h40 -> prediction uses the old entry.
- PC at 32'hFFFF_FFFC with no stall or redirect -> pcPlus4F=0 and next pcF=0. rst asserted mid-sequence with updEn=1 -> pcF=RESET_PC and the BTB is empty.

Source files
------------

// File: rtl/stage_fetch.sv
// stage_fetch: instruction-fetch stage (PC register, optional direct-mapped BTB with
//   2-bit counters).
// Latency: outputs are combinational from the PC; next PC is registered on each clk edge.
// Backpressure: stall holds the PC. A redirect overrides stall. BTB training ignores stall.
//
// Optional feature macro: STAGE_FETCH_BPRED_EN
//   defined   -> BTB built; taken predictions steer the next PC.
//   undefined -> no BTB; bPredictedTakenF = 0; upd* inputs ignored.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   stall, redirect, redirectPc          - PC control from decode/execute
//   updEn, updPc, updTarget, updTaken    - BTB training from execute
//   imemAddr / imemData                  - instruction memory (combinational read)
//   instrF, pcF, pcPlus4F, bPredictedTakenF - fetch/decode interface
module stage_fetch #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    input  logic        updEn,
    input  logic [31:0] updPc,
    input  logic [31:0] updTarget,
    input  logic        updTaken,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        bPredictedTakenF
);

    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    assign pcF      = pc;
    assign imemAddr = pc;
    assign pcPlus4F = pc + 32'd4;
    assign instrF   = imemData;
    assign bPredictedTakenF = pred_taken;

`ifdef STAGE_FETCH_BPRED_EN
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 32 - IDX - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [29:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    // Lookup for the current PC; reads registered contents, so an update in the
    // same cycle is only seen from the next cycle on.
    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;

    assign lk_idx      = pc[IDX+1:2];
    assign lk_tag      = pc[31:IDX+2];
    assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && btb_ctr[lk_idx][1];
    assign pred_target = {btb_target[lk_idx], 2'b00};

    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    assign up_idx = updPc[IDX+1:2];
    assign up_tag = updPc[31:IDX+2];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // Only valid bits are reset; tag/target/ctr are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (updEn) begin
            if (up_hit) begin
                if (updTaken) begin
                    if (btb_ctr[up_idx] != 2'b11)
                        btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                    btb_target[up_idx] <= updTarget[31:2];
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (updTaken) begin
                // Allocate (or evict an aliasing entry) as weakly taken.
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= updTarget[31:2];
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end

    // Low address bits are word-offset and carry no information here.
    logic unused_bits;
    assign unused_bits = ^{redirectPc[1:0], updPc[1:0], updTarget[1:0]};
`else
    assign pred_taken  = 1'b0;
    assign pred_target = 32'h0000_0000;

    logic unused_bits;
    assign unused_bits = ^{redirectPc[1:0], updEn, updPc, updTarget, updTaken,
                           pred_target};
`endif

    // Next-PC priority: reset, redirect, stall, predicted target, sequential.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= {redirectPc[31:2], 2'b00};
        else if (!stall) begin
            if (pred_taken)
                pc <= pred_target;
            else
                pc <= pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
module tb_stage_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] IMEM_K = 32'h5A5A_1234;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, updEn, updTaken;
    logic [31:0] redirectPc, updPc, updTarget;
    logic [31:0] imemAddr, imemData, instrF, pcF, pcPlus4F;
    logic        bPredictedTakenF;

    always #5 clk = ~clk;

    // Instruction memory stand-in: word is a fixed function of its address.
    assign imemData = imemAddr ^ IMEM_K;

    stage_fetch #(.BTB_ENTRIES(16), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirectPc(redirectPc), .updEn(updEn), .updPc(updPc),
        .updTarget(updTarget), .updTaken(updTaken), .imemAddr(imemAddr),
        .imemData(imemData), .instrF(instrF), .pcF(pcF), .pcPlus4F(pcPlus4F),
        .bPredictedTakenF(bPredictedTakenF)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model. BTB entries remember the full PC they were trained with;
    // a lookup hits when the stored PC shares the same 64-byte-aligned region.
    logic [31:0] m_pc;
    bit          m_valid [16];
    logic [31:0] m_owner [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot(a)] && ((m_owner[slot(a)] >> 6) == (a >> 6));
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
`ifdef STAGE_FETCH_BPRED_EN
        return m_hit(a) && (m_ctr[slot(a)] >= 2);
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } exp_t;
    exp_t sb[$];

    // One clock of stimulus: compare current outputs against the scoreboard,
    // advance the model, push the expectation for the next cycle.
    task automatic cyc(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                       input bit ue, input logic [31:0] upc, input logic [31:0] utg,
                       input bit ut);
        exp_t e;
        logic [31:0] nxt;
        int k;
        rst = r; stall = st; redirect = rd; redirectPc = rpc;
        updEn = ue; updPc = upc; updTarget = utg; updTaken = ut;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pcF", pcF, e.pc);
            check("imemAddr", imemAddr, e.pc);
            check("pcPlus4F", pcPlus4F, e.pc + 32'd4);
            check("instrF", instrF, e.pc ^ IMEM_K);
            check("pred", {31'd0, bPredictedTakenF}, {31'd0, e.pred});
        end
        if (r) nxt = RST_PC;
        else if (rd) nxt = rpc & 32'hFFFF_FFFC;
        else if (st) nxt = m_pc;
        else if (m_pred(m_pc)) nxt = m_tgt[slot(m_pc)];
        else nxt = m_pc + 32'd4;
        if (r) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else if (ue) begin
`ifdef STAGE_FETCH_BPRED_EN
            k = slot(upc);
            if (m_hit(upc)) begin
                if (ut) begin
                    m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                    m_tgt[k] = utg & 32'hFFFF_FFFC;
                end else begin
                    m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[k] = 1; m_owner[k] = upc;
                m_tgt[k] = utg & 32'hFFFF_FFFC; m_ctr[k] = 2;
            end
`else
            k = 0;
`endif
        end
        m_pc = nxt;
        e.pc = nxt;
        e.pred = m_pred(nxt);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic go(input logic [31:0] a);
        cyc(0, 0, 1, a, 0, 0, 0, 0);
    endtask
    task automatic train(input logic [31:0] a, input logic [31:0] t, input bit tk);
        cyc(0, 1, 0, 0, 1, a, t, tk);
    endtask

    initial begin
        m_pc = RST_PC;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_pcF", pcF, 32'h100);
        check("rst_pcPlus4F", pcPlus4F, 32'h104);
        check("rst_pred", {31'd0, bPredictedTakenF}, 32'd0);
        run(4);
        #1;
        check("free_pcF", pcF, 32'h110);

        // Stall, then redirect beating stall.
        go(32'h20);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("stall_pcF", pcF, 32'h20);
        cyc(0, 1, 1, 32'h203, 0, 0, 0, 0);
        #1;
        check("redir_pcF", pcF, 32'h200);

        // Train taken, then weaken to not-taken.
        train(32'h40, 32'h80, 1);
        go(32'h40); run(3);
        train(32'h40, 32'h80, 0);
        train(32'h40, 32'h80, 0);
        go(32'h40); run(2);

        // Saturation then single decrement.
        for (int i = 0; i < 5; i++) train(32'h40, 32'h80, 1);
        train(32'h40, 32'h80, 0);
        go(32'h40); run(2);

        // Not-taken miss must not allocate.
        train(32'h44, 32'h300, 0);
        go(32'h44); run(2);

        // Aliasing: 0x80 evicts 0x40.
        train(32'h40, 32'hC0, 1);
        train(32'h80, 32'h400, 1);
        go(32'h40); run(2);
        go(32'h80); run(2);

        // Same-cycle update/lookup of 0x40 sees the old (aliased) entry.
        go(32'h40);
        cyc(0, 0, 0, 0, 1, 32'h40, 32'h500, 1);
        go(32'h40); run(2);

        // Training during stall still lands.
        cyc(0, 1, 0, 0, 1, 32'h104, 32'h600, 1);
        go(32'h104); run(2);

        // Wrap-around.
        go(32'hFFFF_FFFC);
        #1;
        check("wrap_pcPlus4F", pcPlus4F, 32'h0);
        run(1);
        #1;
        check("wrap_pcF", pcF, 32'h0);
        run(1);

        // Mid-run reset with a training request that must be dropped.
        cyc(1, 0, 0, 0, 1, 32'h100, 32'h700, 1);
        #1;
        check("midrst_pcF", pcF, RST_PC);
        run(3);
        go(32'h80); run(2);
        go(32'h40); run(2);

        // Random traffic in a small PC window.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, t;
            a = {24'd0, 2'b0, 6'($urandom_range(0, 63))} << 2;
            t = {24'd0, 2'b0, 6'($urandom_range(0, 63))} << 2;
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0), a | 32'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), t, a, ($urandom_range(0, 2) != 0));
        end
        run(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
